// File: rtl/multicycle_control_unit_if.sv
// rtl/multicycle_control_unit_if.sv - control unit <-> datapath bundle; MCU_ILLEGAL_TRAP_EN adds illegal_op
interface multicycle_control_unit_if #(
  parameter int OPCODE_WIDTH = 3,
  parameter int ALUOP_WIDTH  = 2
);
  logic [OPCODE_WIDTH-1:0] opcode;
  logic                    mem_ready;
  logic                    zero;
  logic                    signal_regdst;
  logic                    signal_regwrite;
  logic                    signal_alusrc;
  logic                    signal_memread;
  logic                    signal_memwrite;
  logic                    signal_memtoreg;
  logic                    signal_branch;
  logic [ALUOP_WIDTH-1:0]  signal_aluop;
  logic                    signal_pcwrite;
  logic [1:0]              signal_pcsrc;
  logic                    signal_irwrite;
  logic                    mem_fault;
  logic                    busy;
`ifdef MCU_ILLEGAL_TRAP_EN
  logic                    illegal_op;
`endif

  modport master (
    input  opcode, mem_ready, zero,
    output
`ifdef MCU_ILLEGAL_TRAP_EN
           illegal_op,
`endif
           signal_regdst, signal_regwrite, signal_alusrc, signal_memread,
           signal_memwrite, signal_memtoreg, signal_branch, signal_aluop,
           signal_pcwrite, signal_pcsrc, signal_irwrite, mem_fault, busy
  );

  modport slave (
    output opcode, mem_ready, zero,
    input
`ifdef MCU_ILLEGAL_TRAP_EN
           illegal_op,
`endif
           signal_regdst, signal_regwrite, signal_alusrc, signal_memread,
           signal_memwrite, signal_memtoreg, signal_branch, signal_aluop,
           signal_pcwrite, signal_pcsrc, signal_irwrite, mem_fault, busy
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM; MCU_ILLEGAL_TRAP_EN adds TRAP state
module multicycle_control_unit #(
  parameter int OPCODE_WIDTH = 3,
  parameter int ALUOP_WIDTH  = 2,
  parameter int MEM_TIMEOUT  = 15
) (
  input  logic                         clock,
  input  logic                         reset_n,
  multicycle_control_unit_if.master    bus
);
  localparam int CNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(MEM_TIMEOUT);

  localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_LOAD  = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_STORE = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ   = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_JUMP  = OPCODE_WIDTH'(5);

  localparam logic [ALUOP_WIDTH-1:0] ALU_SUB   = ALUOP_WIDTH'(1);
  localparam logic [ALUOP_WIDTH-1:0] ALU_FUNCT = ALUOP_WIDTH'(2);

  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB
`ifdef MCU_ILLEGAL_TRAP_EN
    , S_TRAP
`endif
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [OPCODE_WIDTH-1:0] opcode_q;
  logic [CNT_W-1:0]        stall_cnt;
  logic                    mem_fault_q;
  logic                    waiting;
  logic                    timeout;
  logic                    illegal;

  assign illegal = (bus.opcode > OP_JUMP);
  assign waiting = ((state == S_FETCH) || (state == S_MEM)) && !bus.mem_ready;
  // A ready on the timeout cycle wins: waiting is already false then.
  assign timeout = (MEM_TIMEOUT != 0) && waiting && (stall_cnt == TIMEOUT_VAL);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_FETCH;
      opcode_q    <= '0;
      stall_cnt   <= '0;
      mem_fault_q <= 1'b0;
    end else begin
      state       <= state_next;
      mem_fault_q <= timeout;
      if (state == S_DECODE) begin
        opcode_q <= bus.opcode;
      end
      if ((state_next != state) || !waiting || timeout) begin
        stall_cnt <= '0;
      end else begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_next          = state;
    bus.signal_regdst   = 1'b0;
    bus.signal_regwrite = 1'b0;
    bus.signal_alusrc   = 1'b0;
    bus.signal_memread  = 1'b0;
    bus.signal_memwrite = 1'b0;
    bus.signal_memtoreg = 1'b0;
    bus.signal_branch   = 1'b0;
    bus.signal_aluop    = '0;
    bus.signal_pcwrite  = 1'b0;
    bus.signal_pcsrc    = 2'b00;
    bus.signal_irwrite  = 1'b0;
`ifdef MCU_ILLEGAL_TRAP_EN
    bus.illegal_op      = 1'b0;
`endif
    case (state)
      S_FETCH: begin
        bus.signal_memread = 1'b1;
        // Strobes are masked while reset is held so nothing is written during reset.
        if (bus.mem_ready) begin
          bus.signal_irwrite = reset_n;
          bus.signal_pcwrite = reset_n;
          state_next         = S_DECODE;
        end
      end
      S_DECODE: begin
        if (illegal) begin
`ifdef MCU_ILLEGAL_TRAP_EN
          state_next = S_TRAP;
`else
          state_next = S_FETCH;
`endif
        end else begin
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        case (opcode_q)
          OP_RTYPE: begin
            bus.signal_aluop = ALU_FUNCT;
            state_next       = S_WB;
          end
          OP_ADDI: begin
            bus.signal_alusrc = 1'b1;
            state_next        = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            bus.signal_alusrc = 1'b1;
            state_next        = S_MEM;
          end
          OP_BEQ: begin
            bus.signal_aluop   = ALU_SUB;
            bus.signal_branch  = 1'b1;
            bus.signal_pcsrc   = PC_BRANCH;
            bus.signal_pcwrite = bus.zero;
            state_next         = S_FETCH;
          end
          OP_JUMP: begin
            bus.signal_pcwrite = 1'b1;
            bus.signal_pcsrc   = PC_JUMP;
            state_next         = S_FETCH;
          end
          default: state_next = S_FETCH;
        endcase
      end
      S_MEM: begin
        bus.signal_memread  = (opcode_q == OP_LOAD);
        bus.signal_memwrite = (opcode_q == OP_STORE);
        if (bus.mem_ready) begin
          state_next = (opcode_q == OP_LOAD) ? S_WB : S_FETCH;
        end else if (timeout) begin
          state_next = S_FETCH;
        end
      end
      S_WB: begin
        bus.signal_regwrite = 1'b1;
        bus.signal_regdst   = (opcode_q == OP_RTYPE);
        bus.signal_memtoreg = (opcode_q == OP_LOAD);
        state_next          = S_FETCH;
      end
`ifdef MCU_ILLEGAL_TRAP_EN
      S_TRAP: begin
        bus.illegal_op = 1'b1;
      end
`endif
      default: state_next = S_FETCH;
    endcase
  end

  assign bus.busy      = (state != S_FETCH);
  assign bus.mem_fault = mem_fault_q;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - vector table, corner sequences and random run against a phase-list model
module tb_multicycle_control_unit;
  localparam int TO = 15;
  localparam int PH_F = 0, PH_D = 1, PH_E = 2, PH_M = 3, PH_W = 4;

  logic clock;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  multicycle_control_unit_if #(.OPCODE_WIDTH(3), .ALUOP_WIDTH(2)) bus ();

  multicycle_control_unit #(.OPCODE_WIDTH(3), .ALUOP_WIDTH(2), .MEM_TIMEOUT(TO)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic ill;
`ifdef MCU_ILLEGAL_TRAP_EN
  assign ill = bus.illegal_op;
`else
  assign ill = 1'b0;
`endif

  logic [15:0] got;
  assign got = {bus.signal_regdst, bus.signal_regwrite, bus.signal_alusrc, bus.signal_memread,
                bus.signal_memwrite, bus.signal_memtoreg, bus.signal_branch, bus.signal_aluop,
                bus.signal_pcwrite, bus.signal_pcsrc, bus.signal_irwrite, bus.mem_fault, bus.busy, ill};

  function automatic logic [15:0] mk(input int rd, rw, as, mr, mw, mt, br, ao, pw, ps, ir, mf, bz, il);
    return {rd[0], rw[0], as[0], mr[0], mw[0], mt[0], br[0], ao[1:0], pw[0], ps[1:0], ir[0], mf[0], bz[0], il[0]};
  endfunction

  logic [15:0] V_FWAIT, V_FRDY, V_FWF, V_DEC, V_EX_R, V_EX_I, V_EX_BT, V_EX_BN, V_EX_J;
  logic [15:0] V_M_LD, V_M_ST, V_WB_R, V_WB_I, V_WB_L, V_TRAP;

  // Model: an instruction is a list of phases; m_idx walks it, memory phases wait on ready.
  int   m_idx, m_op, m_stall;
  logic m_fault, m_trap;

  function automatic int n_phases(input int op);
    case (op)
      0, 2, 4: return 4;
      1:       return 5;
      3, 5:    return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int phase_of(input int op, input int idx);
    case (idx)
      0: return PH_F;
      1: return PH_D;
      2: return PH_E;
      3: return (op == 1 || op == 2) ? PH_M : PH_W;
      default: return PH_W;
    endcase
  endfunction

  function automatic logic [15:0] exp_model(input logic rst_v, input logic rdy, input logic z);
    if (!rst_v) return V_FWAIT;
    if (m_trap) return V_TRAP;
    case (phase_of(m_op, m_idx))
      PH_F: return mk(0, 0, 0, 1, 0, 0, 0, 0, int'(rdy), 0, int'(rdy), int'(m_fault), 0, 0);
      PH_D: return V_DEC;
      PH_E: begin
        case (m_op)
          0:       return V_EX_R;
          3:       return mk(0, 0, 0, 0, 0, 0, 1, 1, int'(z), 1, 0, 0, 1, 0);
          5:       return V_EX_J;
          default: return V_EX_I;
        endcase
      end
      PH_M:    return (m_op == 1) ? V_M_LD : V_M_ST;
      default: return mk(int'(m_op == 0), 1, 0, 0, 0, int'(m_op == 1), 0, 0, 0, 0, 0, 0, 1, 0);
    endcase
  endfunction

  task automatic model_reset();
    m_idx = 0; m_op = 0; m_stall = 0; m_fault = 1'b0; m_trap = 1'b0;
  endtask

  task automatic advance(input logic rdy, input int opc);
    logic f;
    int   ph;
    f = 1'b0;
    if (!m_trap) begin
      ph = phase_of(m_op, m_idx);
      if (ph == PH_F || ph == PH_M) begin
        if (rdy) begin
          m_stall = 0;
          m_idx = (m_idx + 1 == n_phases(m_op)) ? 0 : m_idx + 1;
        end else if (TO != 0 && m_stall == TO) begin
          f = 1'b1; m_stall = 0; m_idx = 0;
        end else begin
          m_stall++;
        end
      end else begin
        if (ph == PH_D) begin
          m_op = opc;
`ifdef MCU_ILLEGAL_TRAP_EN
          if (opc > 5) m_trap = 1'b1;
`endif
        end
        m_idx = (m_idx + 1 == n_phases(m_op)) ? 0 : m_idx + 1;
      end
    end
    m_fault = f;
  endtask

  task automatic cyc(input logic rst_v, input int op, input logic rdy, input logic z,
                     input logic [15:0] exp, input string name);
    @(negedge clock);
    reset_n       = rst_v;
    bus.opcode    = op[2:0];
    bus.mem_ready = rdy;
    bus.zero      = z;
    #1;
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t got %h exp %h", name, $time, got, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    int          op;
    logic        rdy;
    logic        z;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   stuck;

  initial begin
    reset_n = 1'b0; bus.opcode = '0; bus.mem_ready = 1'b0; bus.zero = 1'b0;
    V_FWAIT = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    V_FRDY  = mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    V_FWF   = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    V_DEC   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    V_EX_R  = mk(0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 1, 0);
    V_EX_I  = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    V_EX_BT = mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 0);
    V_EX_BN = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 1, 0);
    V_EX_J  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 1, 0);
    V_M_LD  = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    V_M_ST  = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    V_WB_R  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    V_WB_I  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    V_WB_L  = mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    V_TRAP  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);

    // One row per cycle: reset, fetch stall, then each opcode with zero-wait memory.
    tbl.push_back('{1'b0, 0, 1'b1, 1'b0, V_FWAIT});
    tbl.push_back('{1'b1, 0, 1'b0, 1'b0, V_FWAIT});
    tbl.push_back('{1'b1, 0, 1'b1, 1'b0, V_FRDY});
    tbl.push_back('{1'b1, 0, 1'b1, 1'b0, V_DEC});
    tbl.push_back('{1'b1, 0, 1'b1, 1'b0, V_EX_R});
    tbl.push_back('{1'b1, 0, 1'b1, 1'b0, V_WB_R});
    tbl.push_back('{1'b1, 3, 1'b1, 1'b1, V_FRDY});
    tbl.push_back('{1'b1, 3, 1'b1, 1'b1, V_DEC});
    tbl.push_back('{1'b1, 3, 1'b1, 1'b1, V_EX_BT});
    tbl.push_back('{1'b1, 3, 1'b1, 1'b0, V_FRDY});
    tbl.push_back('{1'b1, 3, 1'b1, 1'b0, V_DEC});
    tbl.push_back('{1'b1, 3, 1'b1, 1'b0, V_EX_BN});
    tbl.push_back('{1'b1, 5, 1'b1, 1'b0, V_FRDY});
    tbl.push_back('{1'b1, 5, 1'b1, 1'b0, V_DEC});
    tbl.push_back('{1'b1, 5, 1'b1, 1'b0, V_EX_J});
    tbl.push_back('{1'b1, 4, 1'b1, 1'b0, V_FRDY});
    tbl.push_back('{1'b1, 4, 1'b1, 1'b0, V_DEC});
    tbl.push_back('{1'b1, 4, 1'b1, 1'b0, V_EX_I});
    tbl.push_back('{1'b1, 4, 1'b1, 1'b0, V_WB_I});
    tbl.push_back('{1'b1, 1, 1'b1, 1'b0, V_FRDY});
    tbl.push_back('{1'b1, 1, 1'b1, 1'b0, V_DEC});
    tbl.push_back('{1'b1, 1, 1'b1, 1'b0, V_EX_I});
    tbl.push_back('{1'b1, 1, 1'b0, 1'b0, V_M_LD});
    tbl.push_back('{1'b1, 1, 1'b0, 1'b0, V_M_LD});
    tbl.push_back('{1'b1, 1, 1'b0, 1'b0, V_M_LD});
    tbl.push_back('{1'b1, 1, 1'b1, 1'b0, V_M_LD});
    tbl.push_back('{1'b1, 1, 1'b1, 1'b0, V_WB_L});
    tbl.push_back('{1'b1, 2, 1'b1, 1'b0, V_FRDY});
    tbl.push_back('{1'b1, 2, 1'b1, 1'b0, V_DEC});
    tbl.push_back('{1'b1, 2, 1'b1, 1'b0, V_EX_I});
    tbl.push_back('{1'b1, 2, 1'b1, 1'b0, V_M_ST});
    tbl.push_back('{1'b1, 0, 1'b0, 1'b0, V_FWAIT});

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].rst, tbl[i].op, tbl[i].rdy, tbl[i].z, tbl[i].exp, $sformatf("vec%0d", i));
    end

    // Reset asserted for two cycles while a LOAD waits in MEM.
    cyc(1'b0, 0, 1'b0, 1'b0, V_FWAIT, "rst_pre");
    cyc(1'b1, 1, 1'b1, 1'b0, V_FRDY, "rst_fetch");
    cyc(1'b1, 1, 1'b1, 1'b0, V_DEC, "rst_dec");
    cyc(1'b1, 1, 1'b1, 1'b0, V_EX_I, "rst_exec");
    cyc(1'b1, 1, 1'b0, 1'b0, V_M_LD, "rst_mem");
    cyc(1'b0, 1, 1'b1, 1'b0, V_FWAIT, "rst_hold0");
    cyc(1'b0, 1, 1'b1, 1'b0, V_FWAIT, "rst_hold1");
    cyc(1'b1, 1, 1'b0, 1'b0, V_FWAIT, "rst_release");
    cyc(1'b1, 0, 1'b1, 1'b0, V_FRDY, "rst_refetch");
    cyc(1'b1, 0, 1'b1, 1'b0, V_DEC, "rst_redecode");

    // STORE with memory stuck: 16 MEM cycles, one fault pulse in FETCH.
    cyc(1'b0, 0, 1'b0, 1'b0, V_FWAIT, "st_rst");
    cyc(1'b1, 2, 1'b1, 1'b0, V_FRDY, "st_fetch");
    cyc(1'b1, 2, 1'b1, 1'b0, V_DEC, "st_dec");
    cyc(1'b1, 2, 1'b1, 1'b0, V_EX_I, "st_exec");
    for (int i = 0; i <= TO; i++) cyc(1'b1, 2, 1'b0, 1'b0, V_M_ST, $sformatf("st_stall%0d", i));
    cyc(1'b1, 2, 1'b0, 1'b0, V_FWF, "st_fault");
    cyc(1'b1, 2, 1'b0, 1'b0, V_FWAIT, "st_fault_clear");

    // Ready on the timeout cycle counts as success.
    cyc(1'b1, 2, 1'b1, 1'b0, V_FRDY, "sim_fetch");
    cyc(1'b1, 2, 1'b1, 1'b0, V_DEC, "sim_dec");
    cyc(1'b1, 2, 1'b1, 1'b0, V_EX_I, "sim_exec");
    for (int i = 0; i < TO; i++) cyc(1'b1, 2, 1'b0, 1'b0, V_M_ST, $sformatf("sim_stall%0d", i));
    cyc(1'b1, 2, 1'b1, 1'b0, V_M_ST, "sim_ready");

    // Timeout while fetching.
    for (int i = 0; i <= TO; i++) cyc(1'b1, 0, 1'b0, 1'b0, V_FWAIT, $sformatf("fetch_stall%0d", i));
    cyc(1'b1, 0, 1'b0, 1'b0, V_FWF, "fetch_fault");
    cyc(1'b1, 0, 1'b0, 1'b0, V_FWAIT, "fetch_fault_clear");

    // Illegal opcode 7.
    cyc(1'b1, 7, 1'b1, 1'b0, V_FRDY, "ill_fetch");
    cyc(1'b1, 7, 1'b1, 1'b0, V_DEC, "ill_dec");
`ifdef MCU_ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++) cyc(1'b1, 0, 1'b1, 1'b1, V_TRAP, $sformatf("ill_trap%0d", i));
    cyc(1'b0, 0, 1'b1, 1'b0, V_FWAIT, "ill_trap_rst");
    cyc(1'b1, 0, 1'b0, 1'b0, V_FWAIT, "ill_trap_exit");
`else
    cyc(1'b1, 0, 1'b1, 1'b0, V_FRDY, "ill_nop_fetch");
    cyc(1'b1, 0, 1'b1, 1'b0, V_DEC, "ill_nop_next");
`endif

    // Random run against the phase-list model.
    cyc(1'b0, 0, 1'b0, 1'b0, V_FWAIT, "rand_rst");
    model_reset();
    stuck = 0;
    for (int i = 0; i < 3000; i++) begin
      logic r, rdy, z;
      int   op;
      r = ($urandom_range(0, 199) != 0);
      if (stuck > 0) begin
        rdy = 1'b0;
        stuck--;
      end else if ($urandom_range(0, 59) == 0) begin
        stuck = $urandom_range(10, 20);
        rdy = 1'b0;
      end else begin
        rdy = ($urandom_range(0, 3) != 0);
      end
      z  = $urandom_range(0, 1) != 0;
      op = $urandom_range(0, 7);
      cyc(r, op, rdy, z, exp_model(r, rdy, z), $sformatf("rand%0d", i));
      if (!r) model_reset();
      else advance(rdy, op);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
